// File: rtl/kersram_wr_ctrl.sv
// Kernel-SRAM write controller: drains a FWFT kernel FIFO into NUM_BANK SRAM
// banks, filling cfg_len words per bank from bank 0 up to cfg_last_bank.
module kersram_wr_ctrl #(
  parameter int NUM_BANK = 8,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 11,
  parameter int BK_W     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W:0]              cfg_len,
  input  logic [BK_W-1:0]              cfg_last_bank,
  input  logic [ADDR_W-1:0]            cfg_base_addr,
  input  logic [DATA_W-1:0]            fifo_data,
  input  logic                         fifo_empty_n,
  output logic                         fifo_read,
  output logic [NUM_BANK-1:0]          sram_cen,
  output logic [NUM_BANK-1:0]          sram_wen,
  output logic [NUM_BANK*ADDR_W-1:0]   sram_addr,
  output logic [NUM_BANK*DATA_W-1:0]   sram_din,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Job configuration, captured on the accepted start cycle.
  logic [ADDR_W:0]     len_r;
  logic [BK_W-1:0]     last_bank_r;
  logic [ADDR_W-1:0]   base_r;

  // Position of the next word to be written.
  logic [BK_W-1:0]     bank_idx;
  logic [ADDR_W-1:0]   word_cnt;

  // Registered SRAM write, presented one cycle after the FIFO transfer.
  logic                wr_vld;
  logic [BK_W-1:0]     wr_bank;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic                xfer;
  logic                bank_end;
  logic                job_end;
  logic                start_ok;

  // FWFT FIFO: the pop request must be combinational so the head word is
  // consumed in the same cycle it is presented.
  assign fifo_read = (state == S_WRITE) & fifo_empty_n;
  assign xfer      = fifo_read & fifo_empty_n;
  assign start_ok  = (state == S_IDLE) & start;

  // word_cnt never exceeds len_r-1, so a one-bit zero extension is enough.
  assign bank_end  = ({1'b0, word_cnt} == (len_r - (ADDR_W+1)'(1)));
  assign job_end   = bank_end & (bank_idx == last_bank_r);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (cfg_len == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (xfer && job_end) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_r       <= '0;
      last_bank_r <= '0;
      base_r      <= '0;
      bank_idx    <= '0;
      word_cnt    <= '0;
    end else if (start_ok) begin
      len_r       <= cfg_len;
      last_bank_r <= cfg_last_bank;
      base_r      <= cfg_base_addr;
      bank_idx    <= '0;
      word_cnt    <= '0;
    end else if (xfer) begin
      if (bank_end) begin
        word_cnt <= '0;
        bank_idx <= bank_idx + BK_W'(1);
      end else begin
        word_cnt <= word_cnt + ADDR_W'(1);
      end
    end
  end

  // Address arithmetic wraps modulo 2^ADDR_W by truncation.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_vld  <= 1'b0;
      wr_bank <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_vld <= xfer;
      if (xfer) begin
        wr_bank <= bank_idx;
        wr_addr <= base_r + word_cnt;
        wr_data <= fifo_data;
      end
    end
  end

  // Only the addressed bank sees an enable and a non-zero slice.
  always_comb begin
    sram_cen  = '1;
    sram_wen  = '1;
    sram_addr = '0;
    sram_din  = '0;
    if (wr_vld) begin
      sram_cen[wr_bank]                     = 1'b0;
      sram_wen[wr_bank]                     = 1'b0;
      sram_addr[wr_bank*ADDR_W +: ADDR_W]   = wr_addr;
      sram_din[wr_bank*DATA_W +: DATA_W]    = wr_data;
    end
  end

endmodule
